// File: rtl/bp_me_axi_pkg.sv
// Shared AXI definitions for the memory-engine AXI blocks: burst encodings,
// the 4 KB page size that no burst may cross, and the burst generator FSM states.
package bp_me_axi_pkg;

  typedef enum logic [1:0] {
    e_axi_fixed = 2'd0,
    e_axi_incr  = 2'd1,
    e_axi_wrap  = 2'd2
  } axi_burst_e;

  localparam int axi_page_bytes_gp = 4096;

  typedef enum logic {
    e_ready = 1'b0,
    e_send  = 1'b1
  } state_e;

endpackage

// File: rtl/bp_me_axi_burst_calc.sv
// Sizes the next legal INCR burst: min(remaining beats, max_beats_p, beats left
// in the 4 KB page) and flags whether that burst finishes the request.
module bp_me_axi_burst_calc
  import bp_me_axi_pkg::*;
#(
  parameter int beats_width_p = 17,
  parameter int max_beats_p   = 256,
  parameter int lg_bytes_p    = 3,
  parameter int burst_width_p = $clog2(max_beats_p) + 1,
  localparam int page_word_width_lp = $clog2(axi_page_bytes_gp) - lg_bytes_p
) (
  input  logic [page_word_width_lp-1:0] page_word_i,
  input  logic [beats_width_p-1:0]      beats_i,
  output logic [burst_width_p-1:0]      burst_o,
  output logic                          last_o
);

  localparam int w0_lp = (beats_width_p > page_word_width_lp + 1)
                       ? beats_width_p : page_word_width_lp + 1;
  localparam int cmp_width_lp = (w0_lp > burst_width_p) ? w0_lp : burst_width_p;

  logic [cmp_width_lp-1:0] beats_c, max_c, bnd_c, min_c;

  assign beats_c = cmp_width_lp'(beats_i);
  assign max_c   = cmp_width_lp'(max_beats_p);
  // Page word is the aligned offset in beats, so the boundary ignores any
  // unaligned low bits of a first burst.
  assign bnd_c   = cmp_width_lp'(axi_page_bytes_gp >> lg_bytes_p) - cmp_width_lp'(page_word_i);

  // NOTE: min_c gets a default before any conditional update, so no latch is inferred.
  always_comb begin
    min_c = beats_c;
    if (max_c < min_c) min_c = max_c;
    if (bnd_c < min_c) min_c = bnd_c;
  end

  assign burst_o = burst_width_p'(min_c);
  assign last_o  = (beats_c == min_c);

endmodule

// File: rtl/bsg_dff_reset_en.sv
// Enabled register with synchronous active-high reset.
module bsg_dff_reset_en #(
  parameter int                 width_p     = 1,
  parameter logic [width_p-1:0] reset_val_p = '0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] data_r;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      data_r <= reset_val_p;
    else if (en_i)
      data_r <= data_i;
  end

  assign data_o = data_r;

endmodule

// File: rtl/bp_me_axi_burst_gen.sv
// Splits a byte-range request {addr, nbytes} into legal AXI4 INCR address
// commands, one per cycle, never crossing a 4 KB page or exceeding max_beats_p.
module bp_me_axi_burst_gen
  import bp_me_axi_pkg::*;
#(
  parameter int axi_addr_width_p = 64,
  parameter int axi_data_width_p = 64,
  parameter int len_width_p      = 16,
  parameter int max_beats_p      = 256
) (
  input  logic                        clk_i,
  input  logic                        reset_i,

  input  logic                        v_i,
  output logic                        ready_and_o,
  input  logic [axi_addr_width_p-1:0] addr_i,
  input  logic [len_width_p-1:0]      nbytes_i,

  output logic                        v_o,
  input  logic                        ready_and_i,
  output logic [axi_addr_width_p-1:0] axaddr_o,
  output logic [7:0]                  axlen_o,
  output logic [2:0]                  axsize_o,
  output logic [1:0]                  axburst_o,
  output logic                        first_o,
  output logic                        last_o
);

  localparam int lg_lp          = $clog2(axi_data_width_p / 8);
  localparam int beats_width_lp = len_width_p + 1;
  localparam int burst_width_lp = $clog2(max_beats_p) + 1;
  localparam int page_lg_lp     = $clog2(axi_page_bytes_gp);

  state_e state_r, state_n;

  logic [axi_addr_width_p-1:0] addr_r, addr_n, next_addr;
  logic [beats_width_lp-1:0]   beats_r, beats_n, req_beats;
  logic                        first_r, first_n;
  logic [burst_width_lp-1:0]   burst;
  logic                        last;
  logic                        accept, send, reg_en;

  bp_me_axi_burst_calc #(
    .beats_width_p(beats_width_lp),
    .max_beats_p  (max_beats_p),
    .lg_bytes_p   (lg_lp),
    .burst_width_p(burst_width_lp)
  ) calc (
    .page_word_i(addr_r[page_lg_lp-1:lg_lp]),
    .beats_i    (beats_r),
    .burst_o    (burst),
    .last_o     (last)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i)
      state_r <= e_ready;
    else
      state_r <= state_n;
  end

  always_comb begin
    state_n     = state_r;
    ready_and_o = 1'b0;
    v_o         = 1'b0;
    unique case (state_r)
      e_ready: begin
        ready_and_o = 1'b1;
        // Empty requests are acknowledged but never leave e_ready.
        if (v_i && (nbytes_i != '0))
          state_n = e_send;
      end
      e_send: begin
        v_o = 1'b1;
        if (ready_and_i && last)
          state_n = e_ready;
      end
      default: state_n = e_ready;
    endcase
  end

  assign accept = v_i & ready_and_o;
  assign send   = v_o & ready_and_i;
  assign reg_en = accept | send;

  // Beat span counted on beat-index boundaries, modulo the counter width, so
  // an address wrap at the top of memory still yields the right count.
  assign req_beats = beats_width_lp'((addr_i + axi_addr_width_p'(nbytes_i)
                                      - axi_addr_width_p'(1)) >> lg_lp)
                   - beats_width_lp'(addr_i >> lg_lp)
                   + beats_width_lp'(1);

  assign next_addr = ((addr_r >> lg_lp) << lg_lp)
                   + (axi_addr_width_p'(burst) << lg_lp);

  assign addr_n  = (state_r == e_ready) ? addr_i : next_addr;
  assign beats_n = (state_r == e_ready) ? req_beats : beats_r - beats_width_lp'(burst);
  assign first_n = (state_r == e_ready);

  bsg_dff_reset_en #(.width_p(axi_addr_width_p)) addr_reg (
    .clk_i, .reset_i, .en_i(reg_en), .data_i(addr_n), .data_o(addr_r)
  );

  bsg_dff_reset_en #(.width_p(beats_width_lp)) beats_reg (
    .clk_i, .reset_i, .en_i(reg_en), .data_i(beats_n), .data_o(beats_r)
  );

  bsg_dff_reset_en #(.width_p(1)) first_reg (
    .clk_i, .reset_i, .en_i(reg_en), .data_i(first_n), .data_o(first_r)
  );

  assign axaddr_o  = addr_r;
  assign axlen_o   = 8'(burst - burst_width_lp'(1));
  assign axsize_o  = 3'(lg_lp);
  assign axburst_o = 2'(e_axi_incr);
  assign first_o   = first_r;
  assign last_o    = last;

endmodule

// File: tb/tb_bp_me_axi_burst_gen.sv
// Directed scoreboard bench: dut 0 uses max_beats_p=256, dut 1 max_beats_p=16,
// both driven by the same request stream.
module tb_bp_me_axi_burst_gen;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    logic        first;
    logic        last;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        v_i;
  logic [63:0] addr_i;
  logic [15:0] nbytes_i;
  logic        ready_and_i;

  logic        ready_and_o [2];
  logic        v_o         [2];
  logic [63:0] axaddr_o    [2];
  logic [7:0]  axlen_o     [2];
  logic [2:0]  axsize_o    [2];
  logic [1:0]  axburst_o   [2];
  logic        first_o     [2];
  logic        last_o      [2];

  exp_t q0[$];
  exp_t q1[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   send_cyc = -1;
  int   acc_cyc  = -1;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  bp_me_axi_burst_gen #(.max_beats_p(256)) dut0 (
    .clk_i(clk_i), .reset_i(reset_i),
    .v_i(v_i), .ready_and_o(ready_and_o[0]), .addr_i(addr_i), .nbytes_i(nbytes_i),
    .v_o(v_o[0]), .ready_and_i(ready_and_i), .axaddr_o(axaddr_o[0]), .axlen_o(axlen_o[0]),
    .axsize_o(axsize_o[0]), .axburst_o(axburst_o[0]), .first_o(first_o[0]), .last_o(last_o[0])
  );

  bp_me_axi_burst_gen #(.max_beats_p(16)) dut1 (
    .clk_i(clk_i), .reset_i(reset_i),
    .v_i(v_i), .ready_and_o(ready_and_o[1]), .addr_i(addr_i), .nbytes_i(nbytes_i),
    .v_o(v_o[1]), .ready_and_i(ready_and_i), .axaddr_o(axaddr_o[1]), .axlen_o(axlen_o[1]),
    .axsize_o(axsize_o[1]), .axburst_o(axburst_o[1]), .first_o(first_o[1]), .last_o(last_o[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int d, input logic [63:0] a, input logic [7:0] l,
                      input logic f, input logic la);
    exp_t e;
    e.addr = a; e.len = l; e.first = f; e.last = la;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic push_both(input logic [63:0] a, input logic [7:0] l,
                           input logic f, input logic la);
    push(0, a, l, f, la);
    push(1, a, l, f, la);
  endtask

  task automatic check_cmd(input int d, input exp_t e);
    chk($sformatf("d%0d_axaddr", d),  axaddr_o[d],  e.addr);
    chk($sformatf("d%0d_axlen", d),   64'(axlen_o[d]),   64'(e.len));
    chk($sformatf("d%0d_axsize", d),  64'(axsize_o[d]),  64'd3);
    chk($sformatf("d%0d_axburst", d), 64'(axburst_o[d]), 64'd1);
    chk($sformatf("d%0d_first", d),   64'(first_o[d]),   64'(e.first));
    chk($sformatf("d%0d_last", d),    64'(last_o[d]),    64'(e.last));
  endtask

  // Scoreboard: each accepted command is compared against the head of its queue.
  always @(negedge clk_i) begin
    if (!reset_i && v_o[0] && ready_and_i) begin
      send_cyc = cyc;
      if (q0.size() == 0) chk("d0_unexpected_cmd", 64'(v_o[0]), 64'd0);
      else                check_cmd(0, q0.pop_front());
    end
  end

  always @(negedge clk_i) begin
    if (!reset_i && v_o[1] && ready_and_i) begin
      if (q1.size() == 0) chk("d1_unexpected_cmd", 64'(v_o[1]), 64'd0);
      else                check_cmd(1, q1.pop_front());
    end
  end

  // Starts just after a posedge; returns at the negedge following acceptance.
  task automatic req(input logic [63:0] a, input logic [15:0] n);
    logic accepted;
    accepted = 1'b0;
    @(posedge clk_i); #1;
    v_i = 1'b1; addr_i = a; nbytes_i = n;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (ready_and_o[0] && ready_and_o[1]) begin
        accepted = 1'b1;
        acc_cyc  = cyc;
        break;
      end
      @(posedge clk_i); #1;
    end
    chk("req_accepted", 64'(accepted), 64'd1);
    @(posedge clk_i); #1;
    v_i = 1'b0;
    @(negedge clk_i);
    chk("d0_v_after_accept", 64'(v_o[0]), 64'(n != 16'd0));
    chk("d1_v_after_accept", 64'(v_o[1]), 64'(n != 16'd0));
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_i);
      if (!v_o[0] && !v_o[1] && ready_and_o[0] && ready_and_o[1] &&
          q0.size() == 0 && q1.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk("idle_reached", 64'(done), 64'd1);
    q0.delete();
    q1.delete();
  endtask

  task automatic push_38beat(input logic full_d1);
    push(0, 64'h2000, 8'd37, 1'b1, 1'b1);
    push(1, 64'h2000, 8'd15, 1'b1, 1'b0);
    if (full_d1) begin
      push(1, 64'h2080, 8'd15, 1'b0, 1'b0);
      push(1, 64'h2100, 8'd5,  1'b0, 1'b1);
    end
  endtask

  initial begin
    reset_i = 1'b1; v_i = 1'b0; addr_i = '0; nbytes_i = '0; ready_and_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_reset_v", d),     64'(v_o[d]),         64'd0);
      chk($sformatf("d%0d_reset_ready", d), 64'(ready_and_o[d]), 64'd1);
    end
    @(posedge clk_i); #1;
    reset_i = 1'b0; ready_and_i = 1'b1;

    // Single aligned burst.
    push_both(64'h1000, 8'd7, 1'b1, 1'b1);
    req(64'h1000, 16'd64);
    wait_idle();

    // 4 KB split from an unaligned-free start.
    push_both(64'h0FF0, 8'd1, 1'b1, 1'b0);
    push_both(64'h1000, 8'd1, 1'b0, 1'b1);
    req(64'h0FF0, 16'd32);
    wait_idle();

    // Unaligned first burst ending exactly at the page boundary.
    push_both(64'h0FFD, 8'd0, 1'b1, 1'b0);
    push_both(64'h1000, 8'd0, 1'b0, 1'b1);
    req(64'h0FFD, 16'd8);
    wait_idle();

    // Unaligned single burst, next request accepted the cycle after the send.
    push_both(64'h1003, 8'd1, 1'b1, 1'b1);
    req(64'h1003, 16'd10);
    push_both(64'h1000, 8'd7, 1'b1, 1'b1);
    req(64'h1000, 16'd64);
    chk("accept_after_send", 64'(acc_cyc), 64'(send_cyc + 1));
    wait_idle();

    // 38 beats: max-beats split on dut 1.
    push_38beat(1'b1);
    req(64'h2000, 16'd300);
    wait_idle();

    // Same with backpressure after the first burst.
    push_38beat(1'b1);
    req(64'h2000, 16'd300);
    @(posedge clk_i); #1;
    ready_and_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("hold_d1_v",     64'(v_o[1]),         64'd1);
      chk("hold_d1_ready", 64'(ready_and_o[1]), 64'd0);
      chk("hold_d0_ready", 64'(ready_and_o[0]), 64'd1);
      if (q1.size() != 0) begin
        chk("hold_d1_axaddr", axaddr_o[1],       q1[0].addr);
        chk("hold_d1_axlen",  64'(axlen_o[1]),   64'(q1[0].len));
        chk("hold_d1_last",   64'(last_o[1]),    64'(q1[0].last));
      end
    end
    @(posedge clk_i); #1;
    ready_and_i = 1'b1;
    wait_idle();

    // Empty request: accepted, nothing emitted.
    req(64'h3000, 16'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("empty_d0_v",     64'(v_o[0]),         64'd0);
      chk("empty_d1_v",     64'(v_o[1]),         64'd0);
      chk("empty_d1_ready", 64'(ready_and_o[1]), 64'd1);
    end

    // Reset after the first burst discards the remainder.
    push_38beat(1'b0);
    req(64'h2000, 16'd300);
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    @(negedge clk_i);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_midreset_v", d),     64'(v_o[d]),         64'd0);
      chk($sformatf("d%0d_midreset_ready", d), 64'(ready_and_o[d]), 64'd1);
    end
    chk("midreset_q_drained", 64'(q0.size() + q1.size()), 64'd0);
    push_38beat(1'b1);
    req(64'h2000, 16'd300);
    wait_idle();

    // Full page: 256-beat limit on dut 0, 16-beat limit on dut 1.
    push(0, 64'h0000, 8'd255, 1'b1, 1'b0);
    push(0, 64'h0800, 8'd255, 1'b0, 1'b1);
    for (int i = 0; i < 32; i++)
      push(1, 64'(i * 128), 8'd15, 1'(i == 0), 1'(i == 31));
    req(64'h0000, 16'd4096);
    wait_idle();

    // Address wrap at the top of memory.
    push_both(64'hFFFF_FFFF_FFFF_FFF8, 8'd0, 1'b1, 1'b0);
    push_both(64'h0000_0000_0000_0000, 8'd0, 1'b0, 1'b1);
    req(64'hFFFF_FFFF_FFFF_FFF8, 16'd16);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
